// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, ALU classes,
// mux selects and the controller state enumeration.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;
  localparam logic [1:0] ALU_SLT  = 2'b11;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_R_EXEC, S_R_WB, S_BEQ, S_JUMP, S_ADDI_EX, S_SLTI_EX, S_I_WB
  } state_e;

endpackage

// File: rtl/main_controller.sv
// Moore FSM sequencing the multi-cycle MIPS datapath; only illegal_op (DECODE)
// and pc_load (zero flag) look at inputs combinationally.
module main_controller
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic [1:0] alu_op,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_load,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src
);

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    alu_op        = ALU_ADD;
    alu_src_b     = SRCB_REG;
    pc_src        = PCSRC_ALU;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    unique case (state_q)
      S_INIT: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = SRCB_FOUR;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // branch target is computed speculatively here for BEQ
        alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_SLTI:      state_d = S_SLTI_EX;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNC;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PCSRC_ALUOUT;
        instr_done    = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = PCSRC_JUMP;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_I_WB;
      end
      S_SLTI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_SLT;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_INIT;
    endcase
  end

  assign pc_load = pc_write | (pc_write_cond & zero);

endmodule

// File: tb/tb_main_controller.sv
// Randomized scoreboard bench: stimulus pushes per-cycle expected control words
// built from an instruction/phase table; a negedge monitor pops and compares.
module tb_main_controller;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BQ = 6'b000100, JP = 6'b000010, AD = 6'b001000,
                         SL = 6'b001010;
  localparam int FET = 1, DEC = 2, MAD = 3, MRD = 4, MWB = 5, MWR = 6, REX = 7,
                 RWB = 8, BEQ = 9, JMP = 10, AEX = 11, SEX = 12, IWB = 13;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] opcode;
  logic zero;
  logic [1:0] alu_op, alu_src_b, pc_src;
  logic pc_write, pc_write_cond, pc_load, i_or_d, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;

  main_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .alu_op(alu_op),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_load(pc_load),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .instr_done(instr_done),
    .illegal_op(illegal_op), .alu_src_b(alu_src_b), .pc_src(pc_src)
  );

  always #5 clk = ~clk;

  logic [18:0] act;
  assign act = {alu_op, alu_src_b, pc_src, pc_write, pc_write_cond, pc_load,
                i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
                reg_write, alu_src_a, instr_done, illegal_op};

  typedef struct {
    logic [18:0] v;
    int          ph;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;

  function automatic bit legal(logic [5:0] op);
    return op inside {LW, SW, RT, BQ, JP, AD, SL};
  endfunction

  // Control word demanded in each phase of an instruction.
  function automatic logic [18:0] ctl(int ph, logic z, logic ill);
    logic [1:0] aop, srcb, psrc;
    logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, dn;
    {aop, srcb, psrc} = '0;
    {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, dn} = '0;
    case (ph)
      FET: begin mr = 1; irw = 1; pw = 1; srcb = 2'b01; end
      DEC: srcb = 2'b11;
      MAD, AEX: begin sa = 1; srcb = 2'b10; end
      SEX: begin sa = 1; srcb = 2'b10; aop = 2'b11; end
      REX: begin sa = 1; aop = 2'b10; end
      MRD: begin mr = 1; iod = 1; end
      MWR: begin mw = 1; iod = 1; dn = 1; end
      MWB: begin rw = 1; m2r = 1; dn = 1; end
      RWB: begin rw = 1; rd = 1; dn = 1; end
      IWB: begin rw = 1; dn = 1; end
      BEQ: begin sa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; dn = 1; end
      JMP: begin pw = 1; psrc = 2'b10; dn = 1; end
      default: ;
    endcase
    return {aop, srcb, psrc, pw, pwc, pw | (pwc & z), iod, mr, mw, irw, m2r,
            rd, rw, sa, dn, ill};
  endfunction

  task automatic check(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h @%0t", n, a, e, $time);
    end
  endtask

  task automatic drive_phase(int ph, logic [5:0] op, bit noise, int zmode);
    exp_t e;
    @(posedge clk); #1;
    zero   = (zmode == 2) ? 1'($urandom) : (zmode == 1);
    opcode = (ph == DEC || ph == MAD || !noise) ? op : 6'($urandom);
    e.v  = ctl(ph, zero, (ph == DEC) && !legal(op));
    e.ph = ph;
    sb.push_back(e);
  endtask

  task automatic run_instr(logic [5:0] op, bit noise, int zmode);
    int seq[$];
    case (op)
      LW: seq = '{FET, DEC, MAD, MRD, MWB};
      SW: seq = '{FET, DEC, MAD, MWR};
      RT: seq = '{FET, DEC, REX, RWB};
      AD: seq = '{FET, DEC, AEX, IWB};
      SL: seq = '{FET, DEC, SEX, IWB};
      BQ: seq = '{FET, DEC, BEQ};
      JP: seq = '{FET, DEC, JMP};
      default: seq = '{FET, DEC};
    endcase
    foreach (seq[i]) drive_phase(seq[i], op, noise, zmode);
  endtask

  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("ph%0d", e.ph), {13'd0, act}, {13'd0, e.v});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops[7];
    logic [5:0] op;
    ops = '{LW, SW, RT, BQ, JP, AD, SL};
    rst_n = 1'b0; opcode = RT; zero = 1'b1;
    #12 check("rst_init", {13'd0, act}, 32'd0);
    @(posedge clk); #1 check("rst_hold0", {13'd0, act}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("init_after_rel", {13'd0, act}, 32'd0);

    run_instr(LW, 1, 2);
    run_instr(BQ, 1, 1);
    run_instr(BQ, 1, 0);
    run_instr(RT, 1, 2);
    run_instr(SL, 1, 2);
    run_instr(6'b111111, 1, 1);
    run_instr(LW, 0, 1);
    run_instr(JP, 1, 1);
    run_instr(SW, 1, 2);
    run_instr(AD, 1, 2);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 7) == 7) begin
        op = 6'($urandom);
        while (legal(op)) op = 6'($urandom);
      end else begin
        op = ops[$urandom_range(0, 6)];
      end
      run_instr(op, 1, 2);
    end

    // Abort an R-type in R_EXEC with an asynchronous reset.
    drive_phase(FET, RT, 1, 2);
    drive_phase(DEC, RT, 1, 2);
    drive_phase(REX, RT, 1, 2);
    @(negedge clk); #2 rst_n = 1'b0;
    #1 check("rst_async", {13'd0, act}, 32'd0);
    zero = 1'b1;
    @(posedge clk); #1 check("rst_hold", {13'd0, act}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("init_after_rel2", {13'd0, act}, 32'd0);
    run_instr(RT, 1, 2);
    run_instr(LW, 1, 2);

    @(posedge clk); @(negedge clk); #1;
    check("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/main_controller.md
MAIN_CONTROLLER -- requirements
Module: main_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports in order: clk, rst_n.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 opcode  input  6  instr[31:26] from the instruction register.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 alu_op  output  2  ALU class to the ALU decoder: 00 add (lw/sw/addi/PC), 01 sub (beq), 10 use func (R-type), 11 slt (slti).
REQ-007 The block SHALL drive these 1-bit outputs: pc_write, pc_write_cond, pc_load, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op.
REQ-008 alu_src_b  output  2  ALU B source: 00 reg B, 01 constant 4, 10 sign-extended immediate, 11 immediate shifted left by 2.
REQ-009 pc_src  output  2  next-PC source: 00 ALU result, 01 ALUOut, 10 jump target.

Function
REQ-010 The controller SHALL be a Moore FSM with states INIT, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, BEQ, JUMP, ADDI_EX, SLTI_EX, I_WB.
REQ-011 Opcodes SHALL be: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, slti 001010.
REQ-012 Transitions SHALL be: INIT->FETCH; FETCH->DECODE; DECODE->{MEM_ADDR for lw/sw, R_EXEC, BEQ, JUMP, ADDI_EX, SLTI_EX} by opcode.
REQ-013 Further transitions SHALL be: MEM_ADDR->MEM_RD for lw, MEM_WR for sw; MEM_RD->MEM_WB; R_EXEC->R_WB; ADDI_EX->I_WB; SLTI_EX->I_WB.
REQ-014 MEM_WB, MEM_WR, R_WB, BEQ, JUMP and I_WB SHALL each go to FETCH.
REQ-015 DECODE with an unlisted opcode SHALL go to FETCH and pulse illegal_op for that one DECODE cycle.
REQ-016 Each output SHALL be 0 in every state unless listed in REQ-017 through REQ-020.
REQ-017 FETCH: mem_read, ir_write, pc_write=1; alu_src_b=01; alu_op=00; pc_src=00. DECODE: alu_src_b=11; alu_op=00.
REQ-018 MEM_ADDR, ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. SLTI_EX: as ADDI_EX but alu_op=11. R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10.
REQ-019 MEM_RD: mem_read, i_or_d=1. MEM_WR: mem_write, i_or_d=1. MEM_WB: reg_write, mem_to_reg=1. R_WB: reg_write, reg_dst=1. I_WB: reg_write=1.
REQ-020 BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01. JUMP: pc_write=1, pc_src=10.
REQ-021 pc_load SHALL be combinational: pc_write OR (pc_write_cond AND zero).
REQ-022 instr_done SHALL be 1 in the final state of every instruction (MEM_WB, MEM_WR, R_WB, BEQ, JUMP, I_WB).
REQ-023 Instruction latency from FETCH entry SHALL be: lw 5, sw 4, R 4, addi 4, slti 4, beq 3, j 3 cycles.
REQ-024 opcode SHALL be sampled only in DECODE and MEM_ADDR; changes in other states SHALL have no effect.

Reset
REQ-025 rst_n low SHALL force state INIT immediately, independent of clk, and hold it while rst_n is low.
REQ-026 In INIT, all outputs SHALL be 0, including pc_load, regardless of zero.
REQ-027 Reset asserted mid-instruction SHALL abort the instruction with no further write strobes; FETCH SHALL be entered on the first rising edge after rst_n deasserts.

Structure
REQ-028 Package mips_ctrl_pkg SHALL hold the opcode constants, alu_op encodings, alu_src_b/pc_src encodings and the state enumeration.
REQ-029 The ALU decoder SHALL import the same alu_op encodings from mips_ctrl_pkg.
REQ-030 The block SHALL be a single module: a state register plus next-state and output logic, with no sub-module.

Verification
REQ-031 Reset: rst_n=0 asserted mid-R_EXEC -> state INIT at once, all outputs 0; after release, FETCH on the next edge with mem_read=ir_write=pc_write=1.
REQ-032 lw (opcode 100011): states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB -> reg_write=1 and mem_to_reg=1 only in cycle 5; instr_done=1 only in cycle 5.
REQ-033 beq with zero=1 in BEQ -> pc_load=1, pc_src=01, alu_op=01; repeated with zero=0 -> pc_load=0; FETCH follows in both cases.
REQ-034 R-type then slti: alu_op=10 in R_EXEC with reg_dst=1 at write-back; alu_op=11 in SLTI_EX with reg_dst=0 at write-back.
REQ-035 Opcode 111111 -> illegal_op=1 for one DECODE cycle, then FETCH; no reg_write, mem_write or pc_load in that instruction after FETCH.
REQ-036 j (000010) -> 3-cycle instruction; pc_write=1 and pc_src=10 in JUMP; opcode toggled during JUMP has no effect.
